// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the parameterised data memory:
//   state_t    - controller FSM state (fill in progress / accepting accesses)
//   INIT_ZERO  - fill pattern: every word cleared
//   INIT_INDEX - fill pattern: word i holds i, truncated to the word width
//   num_bytes  - number of byte lanes in a word of the given width
// -----------------------------------------------------------------------------
package data_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam int unsigned INIT_ZERO  = 0;
    localparam int unsigned INIT_INDEX = 1;

    function automatic int unsigned num_bytes(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Word storage with one byte-enabled write port and one registered read port.
// The storage itself has no reset; only the read register is clearable.
//
// Ports:
//   clock    - rising-edge clock
//   wr_en    - write strobe
//   wr_addr  - write word address (caller guarantees < DEPTH when wr_en=1)
//   wr_data  - write data
//   wr_be    - byte enables, bit k gates wr_data[8k+7:8k]
//   rd_en    - load the read register this edge
//   rd_zero  - with rd_en: load zero instead of a stored word
//   rd_clr   - clear the read register (has priority over rd_en)
//   rd_addr  - read word address (only used when rd_zero=0)
//   rd_data  - registered read data, holds between loads
// -----------------------------------------------------------------------------
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                           clock,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic [num_bytes(DATA_W)-1:0]   wr_be,
    input  logic                           rd_en,
    input  logic                           rd_zero,
    input  logic                           rd_clr,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic [DATA_W-1:0]              rd_data
);

    localparam int unsigned NBYTES = num_bytes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/data_mem_param.sv
// -----------------------------------------------------------------------------
// data_mem_param
// Single-port data memory with byte enables, a power-up / on-demand fill
// sequence and out-of-range detection.
//
// After reset (or an init_req while idle) the controller spends exactly DEPTH
// cycles writing the INIT_MODE pattern into every word; ready is low for that
// time and requests are ignored. While idle, a request is accepted when
// req=1 and ready=1; reads return data one cycle later with an rvalid pulse,
// and any access with address >= DEPTH raises a one-cycle err pulse at the
// same point (out-of-range writes are dropped, reads return zero).
//
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous, active-low reset
//   req      - access request
//   we       - 1 = write, 0 = read
//   address  - word address
//   wdata    - write data
//   be       - byte enables for writes
//   init_req - start a full re-fill (honoured only while idle)
//   rdata    - read data, holds until the next read or reset
//   rvalid   - one-cycle pulse: rdata updated by an accepted read
//   ready    - 1 while accesses are accepted
//   err      - one-cycle pulse: accepted access was out of range
// -----------------------------------------------------------------------------
module data_mem_param
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned INIT_MODE = INIT_INDEX
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req,
    input  logic                           we,
    input  logic [ADDR_W-1:0]              address,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [num_bytes(DATA_W)-1:0]   be,
    input  logic                           init_req,
    output logic [DATA_W-1:0]              rdata,
    output logic                           rvalid,
    output logic                           ready,
    output logic                           err
);

    localparam int unsigned       NBYTES    = num_bytes(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   fill_cnt;
    logic                fill_last;
    logic [DATA_W-1:0]   fill_data;
    logic                accept;
    logic                in_range;

    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [DATA_W-1:0]   mem_wr_data;
    logic [NBYTES-1:0]   mem_wr_be;
    logic                mem_rd_en;

    assign in_range  = ({1'b0, address} < DEPTH_EXT);
    assign fill_last = (fill_cnt == LAST_WORD);
    assign accept    = req && ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_INIT: if (fill_last) state_next = ST_IDLE;
            ST_IDLE: if (init_req)  state_next = ST_INIT;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        ready = (state == ST_IDLE);
    end

    // ---------------------------------------------------------- fill counter
    // Counter sits at zero whenever no fill is running, so entering INIT
    // from IDLE always starts at word 0 without an explicit load.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fill_cnt <= '0;
        end else if ((state == ST_INIT) && !fill_last) begin
            fill_cnt <= fill_cnt + ADDR_W'(1);
        end else begin
            fill_cnt <= '0;
        end
    end

    always_comb begin
        fill_data = '0;
        if (INIT_MODE == INIT_INDEX) begin
            fill_data = DATA_W'(fill_cnt);
        end
    end

    // ------------------------------------------------------ write port mux
    // The fill owns the write port during INIT; user writes only get it in
    // IDLE. Nothing is written on a reset edge.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_addr = address;
        mem_wr_data = wdata;
        mem_wr_be   = be;
        if (reset) begin
            if (state == ST_INIT) begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = fill_cnt;
                mem_wr_data = fill_data;
                mem_wr_be   = '1;
            end else if (accept && we && in_range) begin
                mem_wr_en   = 1'b1;
            end
        end
    end

    assign mem_rd_en = reset && accept && !we;

    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock   (clock),
        .wr_en   (mem_wr_en),
        .wr_addr (mem_wr_addr),
        .wr_data (mem_wr_data),
        .wr_be   (mem_wr_be),
        .rd_en   (mem_rd_en),
        .rd_zero (!in_range),
        .rd_clr  (!reset),
        .rd_addr (address),
        .rd_data (rdata)
    );

    // ------------------------------------------------------ response pulses
    always_ff @(posedge clock) begin
        if (!reset) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= accept && !we;
            err    <= accept && !in_range;
        end
    end

endmodule

// File: tb/tb_data_mem_param.sv
// -----------------------------------------------------------------------------
// tb_data_mem_param
// Drives a default-parameter instance and a DEPTH=20 instance from shared
// inputs; read expectations go through per-instance queues and are popped
// when the read response is due.
// -----------------------------------------------------------------------------
module tb_data_mem_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [4:0]  address;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        init_req;

    logic [15:0] rdata;
    logic        rvalid, ready, err;
    logic [15:0] rdata20;
    logic        rvalid20, ready20, err20;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sb[$];
    logic [15:0] sb20[$];

    always #5 clock = ~clock;

    data_mem_param #(
        .DATA_W    (16),
        .ADDR_W    (5),
        .DEPTH     (32),
        .INIT_MODE (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .address  (address),
        .wdata    (wdata),
        .be       (be),
        .init_req (init_req),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .ready    (ready),
        .err      (err)
    );

    data_mem_param #(
        .DATA_W    (16),
        .ADDR_W    (5),
        .DEPTH     (20),
        .INIT_MODE (1)
    ) dut20 (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .address  (address),
        .wdata    (wdata),
        .be       (be),
        .init_req (init_req),
        .rdata    (rdata20),
        .rvalid   (rvalid20),
        .ready    (ready20),
        .err      (err20)
    );

    // Called at a falling edge; presents one request for one rising edge and
    // returns at the following falling edge, when that edge's results show.
    task automatic drive(input logic w, input logic [4:0] a,
                         input logic [15:0] d, input logic [1:0] b);
        req = 1'b1; we = w; address = a; wdata = d; be = b;
        @(negedge clock);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        int c, c20, cyc;
        reset = 1'b0; req = 1'b0; we = 1'b0; address = '0;
        wdata = '0; be = '0; init_req = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_checks++;
        if (rvalid !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses rvalid=%b err=%b exp=0/0", rvalid, err);
        end
        n_checks++;
        if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        reset = 1'b1;
        c = 0; c20 = 0; cyc = 0;
        while (!(ready === 1'b1 && ready20 === 1'b1) && cyc < 200) begin
            if (ready !== 1'b1)   c++;
            if (ready20 !== 1'b1) c20++;
            @(negedge clock);
            cyc++;
        end
        n_checks++;
        if (c != 32) begin n_fail++; $display("FAIL init_len got=%0d exp=32", c); end
        n_checks++;
        if (c20 != 20) begin n_fail++; $display("FAIL init_len_d20 got=%0d exp=20", c20); end
    endtask

    task automatic test_index_reads();
        logic [4:0]  addrs [3];
        logic [15:0] exp;
        addrs[0] = 5'd0; addrs[1] = 5'd17; addrs[2] = 5'd31;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(16'(addrs[i]));
            drive(1'b0, addrs[i], 16'h0, 2'b00);
            exp = sb.pop_front();
            n_checks++;
            if (rvalid !== 1'b1) begin n_fail++; $display("FAIL idx_rvalid a=%0d got=%b exp=1", addrs[i], rvalid); end
            n_checks++;
            if (rdata !== exp) begin n_fail++; $display("FAIL idx_rdata a=%0d got=%h exp=%h", addrs[i], rdata, exp); end
            @(negedge clock);
            n_checks++;
            if (rvalid !== 1'b0) begin n_fail++; $display("FAIL idx_pulse a=%0d got=%b exp=0", addrs[i], rvalid); end
        end
    endtask

    task automatic test_byte_enable();
        logic [15:0] exp;
        drive(1'b1, 5'd5, 16'hABCD, 2'b01);
        n_checks++;
        if (rvalid !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL wr_pulses rvalid=%b err=%b exp=0/0", rvalid, err);
        end
        sb.push_back(16'h00CD);
        drive(1'b0, 5'd5, 16'h0, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            n_fail++; $display("FAIL be_low rvalid=%b got=%h exp=%h", rvalid, rdata, exp);
        end
        drive(1'b1, 5'd5, 16'h1234, 2'b10);
        sb.push_back(16'h12CD);
        drive(1'b0, 5'd5, 16'h0, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            n_fail++; $display("FAIL be_high rvalid=%b got=%h exp=%h", rvalid, rdata, exp);
        end
        drive(1'b1, 5'd5, 16'hFFFF, 2'b00);
        sb.push_back(16'h12CD);
        drive(1'b0, 5'd5, 16'h0, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            n_fail++; $display("FAIL be_none rvalid=%b got=%h exp=%h", rvalid, rdata, exp);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] exp;
        sb20.push_back(16'h0013);
        drive(1'b0, 5'd19, 16'h0, 2'b00);
        exp = sb20.pop_front();
        n_checks++;
        if (rvalid20 !== 1'b1 || rdata20 !== exp || err20 !== 1'b0) begin
            n_fail++; $display("FAIL oor_rd19a rvalid=%b err=%b got=%h exp=%h", rvalid20, err20, rdata20, exp);
        end
        drive(1'b1, 5'd25, 16'hFFFF, 2'b11);
        n_checks++;
        if (err20 !== 1'b1 || rvalid20 !== 1'b0) begin
            n_fail++; $display("FAIL oor_wr_err err=%b rvalid=%b exp=1/0", err20, rvalid20);
        end
        @(negedge clock);
        n_checks++;
        if (err20 !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse got=%b exp=0", err20); end
        sb20.push_back(16'h0000);
        drive(1'b0, 5'd25, 16'h0, 2'b00);
        exp = sb20.pop_front();
        n_checks++;
        if (rvalid20 !== 1'b1 || err20 !== 1'b1 || rdata20 !== exp) begin
            n_fail++; $display("FAIL oor_rd25 rvalid=%b err=%b got=%h exp=%h", rvalid20, err20, rdata20, exp);
        end
        sb20.push_back(16'h0013);
        drive(1'b0, 5'd19, 16'h0, 2'b00);
        exp = sb20.pop_front();
        n_checks++;
        if (rvalid20 !== 1'b1 || rdata20 !== exp || err20 !== 1'b0) begin
            n_fail++; $display("FAIL oor_rd19b rvalid=%b err=%b got=%h exp=%h", rvalid20, err20, rdata20, exp);
        end
        sb20.push_back(16'h0009);
        drive(1'b0, 5'd9, 16'h0, 2'b00);
        exp = sb20.pop_front();
        n_checks++;
        if (rvalid20 !== 1'b1 || rdata20 !== exp) begin
            n_fail++; $display("FAIL oor_alias rvalid=%b got=%h exp=%h", rvalid20, rdata20, exp);
        end
    endtask

    task automatic test_init_req();
        logic [15:0] exp;
        int c, cyc;
        drive(1'b1, 5'd3, 16'hBEEF, 2'b11);
        sb.push_back(16'hBEEF);
        req = 1'b1; we = 1'b0; address = 5'd3; init_req = 1'b1;
        @(negedge clock);
        req = 1'b0; init_req = 1'b0;
        exp = sb.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            n_fail++; $display("FAIL init_rd rvalid=%b got=%h exp=%h", rvalid, rdata, exp);
        end
        c = 0; cyc = 0;
        while (ready !== 1'b1 && cyc < 200) begin
            c++;
            init_req = (c == 10);
            @(negedge clock);
            cyc++;
        end
        init_req = 1'b0;
        n_checks++;
        if (c != 32) begin n_fail++; $display("FAIL reinit_len got=%0d exp=32", c); end
        sb.push_back(16'h0003);
        drive(1'b0, 5'd3, 16'h0, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            n_fail++; $display("FAIL reinit_rd rvalid=%b got=%h exp=%h", rvalid, rdata, exp);
        end
    endtask

    task automatic test_reset_mid_init();
        logic [15:0] exp;
        int c, cyc;
        bit stray;
        // Read in flight when reset hits: reset must win.
        req = 1'b1; we = 1'b0; address = 5'd17; reset = 1'b0;
        @(negedge clock);
        req = 1'b0;
        n_checks++;
        if (rvalid !== 1'b0 || err !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_inflight rvalid=%b err=%b ready=%b exp=0/0/0", rvalid, err, ready);
        end
        n_checks++;
        if (rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
        reset = 1'b1;
        repeat (10) @(negedge clock);
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", ready); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        c = 0; cyc = 0; stray = 1'b0;
        while (ready !== 1'b1 && cyc < 200) begin
            c++;
            if (rvalid !== 1'b0 || err !== 1'b0) stray = 1'b1;
            req = (c >= 5 && c <= 7);
            we = (c == 5);
            address = (c == 7) ? 5'd30 : 5'd7;
            wdata = 16'hDEAD; be = 2'b11;
            @(negedge clock);
            cyc++;
        end
        req = 1'b0; we = 1'b0;
        n_checks++;
        if (c != 32) begin n_fail++; $display("FAIL mid_init_len got=%0d exp=32", c); end
        n_checks++;
        if (stray !== 1'b0) begin n_fail++; $display("FAIL busy_req_resp got=%b exp=0", stray); end
        sb.push_back(16'h0007);
        drive(1'b0, 5'd7, 16'h0, 2'b00);
        exp = sb.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            n_fail++; $display("FAIL busy_no_write rvalid=%b got=%h exp=%h", rvalid, rdata, exp);
        end
    endtask

    initial begin
        test_reset();
        test_index_reads();
        test_byte_enable();
        test_out_of_range();
        test_init_req();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_param.md
DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 Parameter DATA_W, default 16, data word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width.
REQ-003 Parameter DEPTH, default 32, number of words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter INIT_MODE, default 1, fill pattern: 0 = all zero, 1 = word i holds value i (truncated to DATA_W).
REQ-005 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 req  in  1  access request; accepted when req=1 and ready=1 on a rising edge.
REQ-008 we  in  1  1 = write, 0 = read; sampled with req.
REQ-009 address  in  ADDR_W  word address.
REQ-010 wdata  in  DATA_W  write data.
REQ-011 be  in  DATA_W/8  byte enables; bit k gates wdata[8k+7:8k].
REQ-012 init_req  in  1  request a full re-fill of memory.
REQ-013 rdata  out  DATA_W  read data.
REQ-014 rvalid  out  1  one-cycle pulse marking rdata valid.
REQ-015 ready  out  1  1 = accesses accepted (state IDLE).
REQ-016 err  out  1  one-cycle pulse on an out-of-range access.

Function
REQ-017 FSM states SHALL be INIT and IDLE only; ready SHALL be 1 exactly in IDLE.
REQ-018 INIT: fill counter starts at 0 and writes the INIT_MODE pattern to word counter once per cycle; after writing word DEPTH-1 the FSM SHALL enter IDLE on the next edge (INIT lasts exactly DEPTH cycles).
REQ-019 Accepted write: bytes with be[k]=1 SHALL update on that edge; bytes with be[k]=0 SHALL keep their value; be=0 SHALL be a no-op.
REQ-020 Accepted read: rdata and rvalid=1 SHALL be registered on that edge (1-cycle latency); rdata SHALL hold until the next accepted read, reset or re-init.
REQ-021 Read of an address written in an earlier cycle SHALL return the new data; reads and writes never share a cycle (single port).
REQ-022 Address >= DEPTH: write SHALL be ignored; read SHALL return rdata=0 with rvalid=1; err=1 in the same cycle rvalid would be (one cycle after accept) for both reads and writes.
REQ-023 req while ready=0 SHALL be ignored: no write, no rvalid, no err.
REQ-024 init_req=1 in IDLE: an access accepted in the same cycle SHALL complete normally; the FSM SHALL enter INIT on that edge, counter=0.
REQ-025 init_req during INIT SHALL be ignored (the fill does not restart).
REQ-026 rvalid and err SHALL be 0 in every cycle not defined above.

Reset
REQ-027 reset=0 on a rising edge SHALL force INIT, counter=0, rdata=0, rvalid=0, err=0, ready=0, from any state including mid-INIT or with a read in flight.
REQ-028 Memory contents SHALL NOT be cleared directly by reset; they SHALL be defined only once the INIT fill that follows reset completes.
REQ-029 reset SHALL take priority over req and init_req.

Structure
REQ-030 Package data_mem_pkg SHALL hold the FSM state type and the INIT_MODE encodings (INIT_ZERO=0, INIT_INDEX=1).
REQ-031 Storage SHALL be a sub-module data_mem_array (byte-enabled write port, registered read port); FSM, fill counter, range check and err/rvalid SHALL stay in data_mem_param.

Verification
REQ-032 Defaults; release reset -> ready=0 for exactly 32 cycles then 1; reads of addresses 0, 17, 31 -> rdata=0x0000, 0x0011, 0x001F, each with rvalid one cycle after accept.
REQ-033 Write address 5, wdata=0xABCD, be=2'b01, then read 5 -> 0x00CD; then write 0x1234 with be=2'b10, read 5 -> 0x12CD.
REQ-034 DEPTH=20: write 0xFFFF to address 25 -> err pulse, no change; read 25 -> rdata=0, rvalid=1, err=1; read 19 -> 0x0013, err=0.
REQ-035 After writing 0xBEEF to address 3, assert init_req together with a read of 3 -> rvalid with 0xBEEF, then ready=0 for 32 cycles; read 3 afterwards -> 0x0003.
REQ-036 Assert reset=0 for one cycle at fill counter 10 -> counter restarts at 0, full 32-cycle INIT follows; req during INIT -> no rvalid, no err, no write.
